// File: rtl/stream_rr_burst_arbiter.sv
// Round-robin valid/ready arbiter granting up to MaxBurst consecutive beats per requester.
// Define STREAM_RR_ARB_LOCK_EN to lock the selection while the sink stalls in IDLE.
module stream_rr_burst_arbiter #(
    parameter int  NumIn    = 4,
    parameter int  MaxBurst = 4,
    parameter type type_t   = logic,
    localparam int IdxWidth = $clog2(NumIn)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  type_t               data_i [NumIn],
    input  logic [NumIn-1:0]    valid_i,
    output logic [NumIn-1:0]    ready_o,
    output type_t               data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [IdxWidth-1:0] grant_idx_o,
    output logic                burst_o
);
    localparam int CntWidth = $clog2(MaxBurst + 1);
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumIn - 1);
    localparam logic [IdxWidth:0]   NumInExt = (IdxWidth + 1)'(NumIn);
    localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxBurst);

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0] cur_q, cur_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] cnt_inc;

    logic [IdxWidth-1:0] cand_idx [NumIn];
    logic [IdxWidth-1:0] sel;
    logic [IdxWidth-1:0] grant_idx;
    logic                fire;

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + 1'b1;
    endfunction

    // cand_idx[i] is the i-th requester in round-robin order starting at rr_ptr
    genvar gi;
    generate
        for (gi = 0; gi < NumIn; gi++) begin : g_scan
            logic [IdxWidth:0] sum;
            assign sum          = {1'b0, rr_ptr_q} + (IdxWidth + 1)'(gi);
            assign cand_idx[gi] = (sum >= NumInExt) ? IdxWidth'(sum - NumInExt) : IdxWidth'(sum);
        end
    endgenerate

    // Scan from the back so the earliest candidate in rotation order wins
    always_comb begin
        sel = rr_ptr_q;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (valid_i[cand_idx[i]]) begin
                sel = cand_idx[i];
            end
        end
    end

    assign grant_idx   = (state_q == BURST) ? cur_q : sel;
    assign valid_o     = ((state_q == BURST) ? valid_i[cur_q] : (|valid_i)) && !flush_i && !rst_i;
    assign fire        = valid_o && ready_i;
    assign data_o      = data_i[grant_idx];
    assign grant_idx_o = rst_i ? '0 : grant_idx;
    assign burst_o     = (state_q == BURST) && !rst_i;
    assign cnt_inc     = cnt_q + 1'b1;

    generate
        for (gi = 0; gi < NumIn; gi++) begin : g_ready
            assign ready_o[gi] = fire && (grant_idx == IdxWidth'(gi));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (MaxBurst == 1) begin
                        rr_ptr_d = next_idx(sel);
                    end else begin
                        cur_d   = sel;
                        cnt_d   = CntWidth'(1);
                        state_d = BURST;
                    end
                end
`ifdef STREAM_RR_ARB_LOCK_EN
                else if (valid_o && !ready_i) begin
                    cur_d   = sel;
                    cnt_d   = '0;
                    state_d = BURST;
                end
`endif
            end
            BURST: begin
                // A dropped valid or an exhausted beat budget both hand priority on
                if (!valid_i[cur_q] || (fire && (cnt_inc == MaxCnt))) begin
                    rr_ptr_d = next_idx(cur_q);
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (fire) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            rr_ptr_d = rr_ptr_q;
            cur_d    = cur_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_stream_rr_burst_arbiter.sv
// Bench for stream_rr_burst_arbiter: directed scenarios plus random traffic against a reference model.
// Two instances: 4 inputs / 4-beat bursts, and 3 inputs / single beats for the wrap case.
module tb_stream_rr_burst_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, flush1, ready1_i, valid1_o, burst1;
    logic [3:0] valid1, ready1_o;
    logic [7:0] data1 [4];
    logic [7:0] data1_o;
    logic [1:0] gidx1;

    logic       rst2, flush2, ready2_i, valid2_o, burst2;
    logic [2:0] valid2, ready2_o;
    logic [7:0] data2 [3];
    logic [7:0] data2_o;
    logic [1:0] gidx2;

    stream_rr_burst_arbiter #(.NumIn(4), .MaxBurst(4), .type_t(logic [7:0])) dut1 (
        .clk_i(clk), .rst_i(rst1), .flush_i(flush1), .data_i(data1), .valid_i(valid1),
        .ready_o(ready1_o), .data_o(data1_o), .valid_o(valid1_o), .ready_i(ready1_i),
        .grant_idx_o(gidx1), .burst_o(burst1)
    );

    stream_rr_burst_arbiter #(.NumIn(3), .MaxBurst(1), .type_t(logic [7:0])) dut2 (
        .clk_i(clk), .rst_i(rst2), .flush_i(flush2), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2_o), .data_o(data2_o), .valid_o(valid2_o), .ready_i(ready2_i),
        .grant_idx_o(gidx2), .burst_o(burst2)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: holding a grant, rotation pointer, owner, beats given
    int h1 = 0, p1 = 0, o1 = 0, b1 = 0;
    int h2 = 0, p2 = 0, o2 = 0, b2 = 0;
    logic        ev1, eb1, ev2, eb2;
    int          ei1, ei2;
    logic [31:0] er1, er2;
    logic [15:0] exp1;
    logic [14:0] exp2;

    wire [15:0] obs1 = {valid1_o, ready1_o, burst1, (valid1_o ? {gidx1, data1_o} : 10'd0)};
    wire [14:0] obs2 = {valid2_o, ready2_o, burst2, (valid2_o ? {gidx2, data2_o} : 10'd0)};

    // Computes this cycle's expected outputs and moves the model to its post-edge state
    task automatic model_step(input int n, input int maxb, input logic [31:0] vld,
                              input logic rdy, input logic fl, input logic rs,
                              inout int hold, inout int ptr, inout int owner, inout int beats,
                              output logic ev, output int eidx, output logic [31:0] erdy,
                              output logic eb);
        bit release_now;
        ev = 1'b0; eidx = 0; erdy = '0; eb = 1'b0; release_now = 1'b0;
        if (rs) begin
            hold = 0; ptr = 0; owner = 0; beats = 0;
            return;
        end
        eb = (hold != 0);
        if (hold != 0) begin
            eidx = owner;
            ev   = vld[owner];
        end else begin
            eidx = ptr;
            for (int i = 0; i < n; i++) begin
                if (vld[(ptr + i) % n]) begin
                    eidx = (ptr + i) % n;
                    ev   = 1'b1;
                    break;
                end
            end
        end
        if (fl) ev = 1'b0;
        if (ev && rdy) erdy = 32'd1 << eidx;
        if (fl) begin
            hold = 0; beats = 0;
            return;
        end
        if (hold != 0) begin
            if (!vld[owner]) release_now = 1'b1;
            else if (rdy) begin
                beats++;
                if (beats == maxb) release_now = 1'b1;
            end
        end else if (ev && rdy) begin
            if (maxb == 1) ptr = (eidx + 1) % n;
            else begin
                hold = 1; owner = eidx; beats = 1;
            end
        end
`ifdef STREAM_RR_ARB_LOCK_EN
        else if (ev) begin
            hold = 1; owner = eidx; beats = 0;
        end
`endif
        if (release_now) begin
            ptr = (owner + 1) % n; hold = 0; beats = 0;
        end
    endtask

    task automatic cyc(input logic [3:0] v1, input logic r1, input logic f1, input logic s1,
                       input logic [2:0] v2, input logic r2, input logic f2, input logic s2);
        @(posedge clk);
        #1;
        valid1 = v1; ready1_i = r1; flush1 = f1; rst1 = s1;
        valid2 = v2; ready2_i = r2; flush2 = f2; rst2 = s2;
        for (int k = 0; k < 4; k++) data1[k] = 8'($urandom);
        for (int k = 0; k < 3; k++) data2[k] = 8'($urandom);
        @(negedge clk);
        model_step(4, 4, {28'd0, v1}, r1, f1, s1, h1, p1, o1, b1, ev1, ei1, er1, eb1);
        model_step(3, 1, {29'd0, v2}, r2, f2, s2, h2, p2, o2, b2, ev2, ei2, er2, eb2);
        exp1 = {ev1, er1[3:0], eb1, (ev1 ? {2'(ei1), data1[ei1]} : 10'd0)};
        exp2 = {ev2, er2[2:0], eb2, (ev2 ? {2'(ei2), data2[ei2]} : 10'd0)};
    endtask

    task automatic test_reset();
        for (int j = 0; j < 2; j++) begin
            cyc(4'b1111, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b1);
            vectors++;
            if ({valid1_o, ready1_o, burst1, gidx1} !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: got valid=%b ready=%b burst=%b idx=%0d, want all 0",
                         valid1_o, ready1_o, burst1, gidx1);
            end
            vectors++;
            if (obs2 !== exp2) begin
                miscompares++;
                $display("FAIL reset_dut2: got %h want %h", obs2, exp2);
            end
        end
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (valid1_o !== 1'b1 || gidx1 !== 2'd0 || ready1_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant: got valid=%b idx=%0d ready=%b, want 1 0 0001",
                     valid1_o, gidx1, ready1_o);
        end
        // Reset landing mid-burst drops the grant
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (ready1_o !== 4'b0000 || valid1_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midburst: got ready=%b valid=%b, want 0000 0", ready1_o, valid1_o);
        end
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (gidx1 !== 2'd0 || burst1 !== 1'b0 || obs1 !== exp1) begin
            miscompares++;
            $display("FAIL reset_regrant: got idx=%0d burst=%b obs=%h, want 0 0 %h",
                     gidx1, burst1, obs1, exp1);
        end
    endtask

    task automatic test_full_load();
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 20; j++) begin
            cyc(4'b1111, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (valid1_o !== 1'b1 || gidx1 !== 2'((j / 4) % 4) || obs1 !== exp1) begin
                miscompares++;
                $display("FAIL full_load j=%0d: got valid=%b idx=%0d obs=%h, want 1 %0d %h",
                         j, valid1_o, gidx1, obs1, (j / 4) % 4, exp1);
            end
        end
    endtask

    task automatic test_early_release();
        logic [3:0] pat [4];
        logic       want_v [4];
        logic [1:0] want_i [4];
        pat[0] = 4'b1100; pat[1] = 4'b1100; pat[2] = 4'b1011; pat[3] = 4'b1011;
        want_v[0] = 1'b1; want_v[1] = 1'b1; want_v[2] = 1'b0; want_v[3] = 1'b1;
        want_i[0] = 2'd2; want_i[1] = 2'd2; want_i[2] = 2'd0; want_i[3] = 2'd3;
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            cyc(pat[j], 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (valid1_o !== want_v[j] || (want_v[j] && gidx1 !== want_i[j]) || obs1 !== exp1) begin
                miscompares++;
                $display("FAIL early_release step=%0d: got valid=%b idx=%0d obs=%h, want %b %0d %h",
                         j, valid1_o, gidx1, obs1, want_v[j], want_i[j], exp1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] want;
`ifdef STREAM_RR_ARB_LOCK_EN
        want = 2'd2;
`else
        want = 2'd0;
`endif
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (valid1_o !== 1'b1 || gidx1 !== 2'd2 || ready1_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL backpressure_first: got valid=%b idx=%0d ready=%b, want 1 2 0000",
                     valid1_o, gidx1, ready1_o);
        end
        for (int j = 0; j < 3; j++) begin
            cyc(4'b0101, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (gidx1 !== want || obs1 !== exp1) begin
                miscompares++;
                $display("FAIL backpressure_hold j=%0d: got idx=%0d obs=%h, want %0d %h",
                         j, gidx1, obs1, want, exp1);
            end
        end
        cyc(4'b0101, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (gidx1 !== want || ready1_o !== (4'b0001 << want) || obs1 !== exp1) begin
            miscompares++;
            $display("FAIL backpressure_release: got idx=%0d ready=%b, want %0d %b",
                     gidx1, ready1_o, want, 4'b0001 << want);
        end
    endtask

    task automatic test_flush();
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) cyc(4'b0001, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0011, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (gidx1 !== 2'd1 || burst1 !== 1'b0 || obs1 !== exp1) begin
            miscompares++;
            $display("FAIL flush_setup: got idx=%0d burst=%b, want 1 0", gidx1, burst1);
        end
        cyc(4'b0011, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0011, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (ready1_o !== 4'b0000 || obs1 !== exp1) begin
            miscompares++;
            $display("FAIL flush_cycle: got ready=%b obs=%h, want 0000 %h", ready1_o, obs1, exp1);
        end
        cyc(4'b0011, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (burst1 !== 1'b0 || gidx1 !== 2'd1 || valid1_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_regrant: got burst=%b idx=%0d valid=%b, want 0 1 1",
                     burst1, gidx1, valid1_o);
        end
        for (int j = 0; j < 5; j++) begin
            cyc(4'b0011, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (obs1 !== exp1) begin
                miscompares++;
                $display("FAIL flush_after j=%0d: got %h want %h", j, obs1, exp1);
            end
        end
    endtask

    task automatic test_wrap();
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 6; j++) begin
            cyc(4'b0000, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
            vectors++;
            if (valid2_o !== 1'b1 || gidx2 !== 2'(j % 3) || burst2 !== 1'b0 || obs2 !== exp2) begin
                miscompares++;
                $display("FAIL wrap j=%0d: got valid=%b idx=%0d burst=%b, want 1 %0d 0",
                         j, valid2_o, gidx2, burst2, j % 3);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            cyc(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
                ($urandom_range(0, 63) == 0),
                3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
                ($urandom_range(0, 63) == 0));
            vectors++;
            if (obs1 !== exp1) begin
                miscompares++;
                $display("FAIL random_dut1 j=%0d: got %h want %h", j, obs1, exp1);
            end
            vectors++;
            if (obs2 !== exp2) begin
                miscompares++;
                $display("FAIL random_dut2 j=%0d: got %h want %h", j, obs2, exp2);
            end
        end
    endtask

    initial begin
        rst1 = 1'b1; flush1 = 1'b0; ready1_i = 1'b0; valid1 = '0;
        rst2 = 1'b1; flush2 = 1'b0; ready2_i = 1'b0; valid2 = '0;
        for (int k = 0; k < 4; k++) data1[k] = '0;
        for (int k = 0; k < 3; k++) data2[k] = '0;
        test_reset();
        test_full_load();
        test_early_release();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
